// File: rtl/can_crc_if.sv
// Bus bundle between a CAN bit-path client and the serial CRC engine.
//
// Handshake: a serial bit on din is consumed on a rising clock edge exactly
// when din_valid and din_ready are both high in the cycle before that edge.
// din_valid may be held low for any number of cycles (gaps); din is ignored
// whenever din_ready is low. start is a one-cycle pulse and is not
// handshaked: it is always accepted and wins over a bit in the same cycle.
interface can_crc_if #(
    parameter int CRC_W = 15,
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             mode;
    logic             din;
    logic             din_valid;
    logic             din_ready;
    logic             busy;
    logic [CRC_W-1:0] crc_out;
    logic             crc_valid;
    logic             crc_ok;

    // Client side: drives frame control and serial bits, observes result.
    modport master (
        output start, len, mode, din, din_valid,
        input  din_ready, busy, crc_out, crc_valid, crc_ok
    );

    // Engine side.
    modport slave (
        input  start, len, mode, din, din_valid,
        output din_ready, busy, crc_out, crc_valid, crc_ok
    );
endinterface

// File: rtl/can_crc_engine.sv
// Serial CRC generator/checker for the CAN TX and RX bit paths.
// Direct (non-augmented) LFSR, MSB-first input, so the remainder is valid right
// after the last payload bit. In CHECK mode the received CRC field is run
// through the same register and the remainder is tested for zero.
module can_crc_engine #(
    parameter int               CRC_W = 15,
    parameter logic [CRC_W-1:0] POLY  = 15'h4599,
    parameter logic [CRC_W-1:0] INIT  = 15'h0000,
    parameter int               LEN_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    can_crc_if.slave    bus,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_CRCF = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [CRC_W-1:0] crc_out_q, crc_out_d;
    logic             crc_ok_q, crc_ok_d;

    logic             take;
    logic [CRC_W-1:0] crc_step;

    // A zero count in DATA only happens for an empty GENERATE frame; no bit is
    // accepted then, the frame just finishes with the INIT value.
    assign bus.din_ready = ((state_q == S_DATA) && (cnt_q != '0)) || (state_q == S_CRCF);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.crc_valid = (state_q == S_DONE);
    assign bus.crc_out   = crc_out_q;
    assign bus.crc_ok    = crc_ok_q;
    assign dbg_state     = state_q;

    assign take = bus.din_valid & bus.din_ready;

    // One LFSR step on the current input bit.
    always_comb begin
        crc_step = {crc_q[CRC_W-2:0], 1'b0} ^ ((bus.din ^ crc_q[CRC_W-1]) ? POLY : '0);
    end

    // Next-state, counter, CRC register and result capture.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        crc_out_d = crc_out_q;
        crc_ok_d  = crc_ok_q;

        if (bus.start) begin
            // Start aborts whatever is in flight and takes priority over a bit.
            crc_d  = INIT;
            mode_d = bus.mode;
            if (bus.mode && (bus.len == '0)) begin
                state_d = S_CRCF;
                cnt_d   = LEN_W'(CRC_W);
            end else begin
                state_d = S_DATA;
                cnt_d   = bus.len;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_DATA: begin
                    if (cnt_q == '0) begin
                        state_d   = S_DONE;
                        crc_out_d = crc_q;
                        crc_ok_d  = 1'b1;
                    end else if (take) begin
                        crc_d = crc_step;
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == LEN_W'(1)) begin
                            if (mode_q) begin
                                state_d = S_CRCF;
                                cnt_d   = LEN_W'(CRC_W);
                            end else begin
                                state_d   = S_DONE;
                                crc_out_d = crc_step;
                                crc_ok_d  = 1'b1;
                            end
                        end
                    end
                end
                S_CRCF: begin
                    if (take) begin
                        crc_d = crc_step;
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == LEN_W'(1)) begin
                            state_d   = S_DONE;
                            crc_out_d = crc_step;
                            crc_ok_d  = (crc_step == '0);
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            crc_q     <= INIT;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            crc_out_q <= '0;
            crc_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            crc_out_q <= crc_out_d;
            crc_ok_q  <= crc_ok_d;
        end
    end

endmodule

// File: tb/tb_can_crc_engine.sv
// Directed and randomised bench for can_crc_engine.
module tb_can_crc_engine;

    localparam int               CRC_W = 15;
    localparam int               LEN_W = 16;
    localparam logic [CRC_W-1:0] POLY  = 15'h4599;
    localparam logic [CRC_W-1:0] INIT  = 15'h0000;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    logic [CRC_W:0] exp_q[$];   // {crc_ok, crc_out}

    can_crc_if #(.CRC_W(CRC_W), .LEN_W(LEN_W)) bus ();

    can_crc_engine #(
        .CRC_W(CRC_W), .POLY(POLY), .INIT(INIT), .LEN_W(LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CRC_W-1:0] crc_model_step(input logic [CRC_W-1:0] c, input logic b);
        logic fb;
        fb = b ^ c[CRC_W-1];
        return {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

    // Scoreboard: every crc_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && bus.crc_valid) begin
            logic [CRC_W:0] e;
            valid_cnt++;
            check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_crc_out", 32'(bus.crc_out), 32'(e[CRC_W-1:0]));
                check("sb_crc_ok", 32'(bus.crc_ok), 32'(e[CRC_W]));
            end
        end
    end

    // Driver tasks: all start and end just after a rising edge.
    task automatic do_start(input int len, input logic mode);
        bus.start = 1'b1;
        bus.len   = LEN_W'(len);
        bus.mode  = mode;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        bus.din_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("busy_in_gap", 32'(bus.busy), 32'd1);
            @(posedge clk); #1;
        end
        bus.din       = b;
        bus.din_valid = 1'b1;
        @(negedge clk);
        check("din_ready", 32'(bus.din_ready), 32'd1);
        @(posedge clk); #1;
        bus.din_valid = 1'b0;
        bus.din       = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] v, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], gap);
    endtask

    task automatic wait_valid(input string tag, output int waited);
        waited = 0;
        @(negedge clk);
        while (!bus.crc_valid && waited < 400) begin
            waited++;
            @(negedge clk);
        end
        check({tag, "_timeout"}, 32'(bus.crc_valid), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic expect_result(input logic ok, input logic [CRC_W-1:0] crc);
        exp_q.push_back({ok, crc});
    endtask

    initial begin
        int w;
        int vbase;
        logic pay[$];
        logic [CRC_W-1:0] m;
        logic [CRC_W-1:0] field;
        int len;
        logic mode;
        int gap;

        rst_n = 1'b0;
        bus.start = 1'b0; bus.len = '0; bus.mode = 1'b0;
        bus.din = 1'b0;   bus.din_valid = 1'b0;

        // Reset values
        #2;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready", 32'(bus.din_ready), 32'd0);
        check("rst_valid", 32'(bus.crc_valid), 32'd0);
        check("rst_crc_out", 32'(bus.crc_out), 32'd0);
        check("rst_crc_ok", 32'(bus.crc_ok), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: GENERATE len=1, bit 1
        expect_result(1'b1, 15'h4599);
        do_start(1, 1'b0);
        check("t1_busy", 32'(bus.busy), 32'd1);
        send_bit(1'b1, 0);
        wait_valid("t1", w);
        check("t1_latency", 32'(w), 32'd0);
        check("t1_crc_out", 32'(bus.crc_out), 32'h4599);
        check("t1_busy_after", 32'(bus.busy), 32'd0);

        // 2: GENERATE len=2, bits 1,0, then gapped
        expect_result(1'b1, 15'h4EAB);
        do_start(2, 1'b0);
        send_word(32'b10, 2, 0);
        wait_valid("t2", w);
        check("t2_latency", 32'(w), 32'd0);
        expect_result(1'b1, 15'h4EAB);
        do_start(2, 1'b0);
        send_word(32'b10, 2, 3);
        wait_valid("t2g", w);
        check("t2g_latency", 32'(w), 32'd0);
        check("t2g_crc_out_held", 32'(bus.crc_out), 32'h4EAB);

        // 3: CHECK len=1, good CRC and one flipped CRC bit (last one)
        expect_result(1'b1, 15'h0000);
        do_start(1, 1'b1);
        send_bit(1'b1, 0);
        check("t3_in_crcf", 32'(dbg_state), 32'd2);
        send_word(32'h4599, 15, 0);
        wait_valid("t3", w);
        check("t3_ok_held", 32'(bus.crc_ok), 32'd1);
        expect_result(1'b0, 15'h4599);
        do_start(1, 1'b1);
        send_bit(1'b1, 0);
        send_word(32'h4598, 15, 1);
        wait_valid("t3b", w);
        check("t3b_ok_held", 32'(bus.crc_ok), 32'd0);

        // 4: GENERATE len=8 zeros, then len=0
        expect_result(1'b1, 15'h0000);
        do_start(8, 1'b0);
        send_word(32'h00, 8, 0);
        wait_valid("t4", w);
        expect_result(1'b1, INIT);
        do_start(0, 1'b0);
        wait_valid("t4z", w);
        check("t4z_latency", 32'(w), 32'd1);

        // 5: abort a len=8 frame after 4 bits
        vbase = valid_cnt;
        do_start(8, 1'b0);
        send_word(32'hB, 4, 0);
        expect_result(1'b1, 15'h4599);
        do_start(1, 1'b0);
        send_bit(1'b1, 0);
        wait_valid("t5", w);
        repeat (5) @(posedge clk);
        #1;
        check("t5_one_valid", 32'(valid_cnt - vbase), 32'd1);

        // 6: reset mid-frame
        do_start(8, 1'b1);
        send_word(32'h5, 3, 0);
        rst_n = 1'b0;
        #2;
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_ready", 32'(bus.din_ready), 32'd0);
        check("t6_valid", 32'(bus.crc_valid), 32'd0);
        check("t6_crc_out", 32'(bus.crc_out), 32'd0);
        check("t6_crc_ok", 32'(bus.crc_ok), 32'd0);
        check("t6_state", 32'(dbg_state), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_result(1'b1, 15'h4599);
        do_start(1, 1'b0);
        send_bit(1'b1, 0);
        wait_valid("t6_after", w);

        // Random frames against the reference model
        for (int f = 0; f < 25; f++) begin
            len  = $urandom_range(0, 200);
            mode = 1'($urandom_range(0, 1));
            pay.delete();
            m = INIT;
            for (int i = 0; i < len; i++) begin
                pay.push_back(1'($urandom_range(0, 1)));
                m = crc_model_step(m, pay[i]);
            end
            field = ($urandom_range(0, 1) == 1) ? m : CRC_W'($urandom_range(0, 32767));
            if (mode) begin
                for (int i = CRC_W - 1; i >= 0; i--) m = crc_model_step(m, field[i]);
                expect_result(m == '0, m);
            end else begin
                expect_result(1'b1, m);
            end
            do_start(len, mode);
            for (int i = 0; i < len; i++) begin
                gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                send_bit(pay[i], gap);
            end
            if (mode) send_word(32'(field), CRC_W, 0);
            wait_valid("rand", w);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
